// File: rtl/div_pkg.sv
// Shared definitions for the divide controller: datapath width, FSM encoding and
// the sign-fixup flags carried from operand acceptance to result writeback.
package div_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // Quotient reported for a zero divisor; the remainder is the dividend itself.
    localparam word_t DIV0_LO = '1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        FIX,
        DONE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } fix_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation: yields |x| for operand preparation and
// applies the sign correction to the unsigned divider results.
module div_sign_fix
    import div_pkg::*;
(
    input  logic [XLEN-1:0] val,
    input  logic            neg,
    output logic [XLEN-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: feeds magnitudes to an external unsigned divider, applies
// the sign fixup and commits HI (remainder) / LO (quotient).
module div_ctrl
    import div_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic            div_req,
    input  logic            div_signed,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            dv_start,
    output logic [XLEN-1:0] dv_a,
    output logic [XLEN-1:0] dv_b,
    input  logic            dv_busy,
    input  logic [XLEN-1:0] dv_q,
    input  logic [XLEN-1:0] dv_r,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_t state;
    fix_t   fix;
    word_t  q_reg;
    word_t  r_reg;
    word_t  abs_a;
    word_t  abs_b;
    word_t  fix_q;
    word_t  fix_r;

    div_sign_fix u_abs_a (
        .val (op_a),
        .neg (div_signed & op_a[XLEN-1]),
        .res (abs_a)
    );

    div_sign_fix u_abs_b (
        .val (op_b),
        .neg (div_signed & op_b[XLEN-1]),
        .res (abs_b)
    );

    div_sign_fix u_fix_q (
        .val (q_reg),
        .neg (fix.neg_q),
        .res (fix_q)
    );

    div_sign_fix u_fix_r (
        .val (r_reg),
        .neg (fix.neg_r),
        .res (fix_r)
    );

    // Combinational so a request arriving in IDLE freezes upstream in the same cycle.
    assign stall = resetn &&
                   ((state inside {LAUNCH, WAIT_ACK, WAIT_DONE, FIX}) ||
                    ((state inside {IDLE, DRAIN}) && div_req && !flush));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the holding registers are reset too, so every output is defined from reset onward.
            state    <= IDLE;
            fix      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            dv_start <= 1'b0;
            dv_a     <= '0;
            dv_b     <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            // NOTE: non-blocking throughout; the low defaults make dv_start and done single-cycle pulses.
            dv_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_req && !flush) begin
                        fix.neg_q <= div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        fix.neg_r <= div_signed & op_a[XLEN-1];
                        if (op_b == '0) begin
                            lo    <= DIV0_LO;
                            hi    <= op_a;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            dv_a     <= abs_a;
                            dv_b     <= abs_b;
                            dv_start <= 1'b1;
                            state    <= LAUNCH;
                        end
                    end
                end
                // dv_start is already on the wire here, so a flush must still drain the divider.
                LAUNCH: begin
                    state <= flush ? DRAIN : WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (dv_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (!dv_busy) begin
                        q_reg <= dv_q;
                        r_reg <= dv_r;
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= dv_busy ? DRAIN : IDLE;
                    end else begin
                        lo    <= fix_q;
                        hi    <= fix_r;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                // Result already committed on entry, so a flush here has nothing to cancel.
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (!dv_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural divider, cycle-level reference
// model compared every cycle, directed corner cases and randomized traffic.
module tb_div_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        div_req = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        dv_start;
    logic [31:0] dv_a;
    logic [31:0] dv_b;
    logic        dv_busy;
    logic [31:0] dv_q;
    logic [31:0] dv_r;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          lat_cfg = 1;
    int          n_tests = 0;
    int          n_fail = 0;

    div_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .div_req    (div_req),
        .div_signed (div_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .dv_start   (dv_start),
        .dv_a       (dv_a),
        .dv_b       (dv_b),
        .dv_busy    (dv_busy),
        .dv_q       (dv_q),
        .dv_r       (dv_r),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Unsigned divider: busy for lat_cfg cycles after start, results masked while busy.
    logic        d_busy;
    logic [31:0] d_q;
    logic [31:0] d_r;
    int          d_cnt;
    int          start_cnt = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d_busy <= 1'b0;
            d_cnt  <= 0;
            d_q    <= '0;
            d_r    <= '0;
        end else if (d_busy) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) d_busy <= 1'b0;
        end else if (dv_start) begin
            d_busy <= 1'b1;
            d_cnt  <= lat_cfg;
            d_q    <= (dv_b == 0) ? 32'hFFFF_FFFF : dv_a / dv_b;
            d_r    <= (dv_b == 0) ? dv_a : dv_a % dv_b;
        end
    end

    always @(posedge clock) begin
        if (resetn && dv_start) start_cnt <= start_cnt + 1;
    end

    assign dv_busy = d_busy;
    assign dv_q    = d_busy ? 32'hDEAD_BEEF : d_q;
    assign dv_r    = d_busy ? 32'hBAD0_BAD0 : d_r;

    // Architectural result of DIV/DIVU straight from the instruction definition.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    // Reference model: edge n is the n-th rising edge since reset release, evaluated
    // on the following falling edge where the DUT outputs are compared.
    int          m_n = 0;
    int          m_e0 = -10;
    int          m_dedge = -10;
    int          m_done_at = -10;
    bit          m_pend = 1'b0;
    bit          m_drain = 1'b0;
    bit          m_busy_prev = 1'b0;
    logic [31:0] m_q, m_r, m_hi, m_lo, m_abs_a, m_abs_b;

    initial begin : model
        bit exp_done, exp_stall, exp_start;
        m_hi = '0;
        m_lo = '0;
        forever begin
            @(negedge clock or negedge resetn);
            if (!resetn) begin
                m_n = 0; m_pend = 0; m_drain = 0; m_busy_prev = 0;
                m_done_at = -10; m_hi = '0; m_lo = '0;
                continue;
            end
            m_n++;
            if (m_done_at == m_n - 1) begin
                // the done cycle ends; nothing is accepted on this edge
            end else if (m_pend) begin
                if (m_n == m_dedge) begin
                    m_pend = 0;
                    if (!flush) begin
                        m_done_at = m_n;
                        m_hi = m_r;
                        m_lo = m_q;
                    end
                end else if (flush) begin
                    m_pend  = 0;
                    m_drain = 1;
                end
            end else if (m_drain) begin
                if (!m_busy_prev) m_drain = 0;
            end else if (div_req && !flush) begin
                ref_div(div_signed, op_a, op_b, m_q, m_r);
                m_e0 = m_n;
                if (op_b == 0) begin
                    m_done_at = m_n;
                    m_hi = m_r;
                    m_lo = m_q;
                end else begin
                    m_pend  = 1;
                    m_dedge = m_n + lat_cfg + 3;
                    m_abs_a = (div_signed && op_a[31]) ? 32'd0 - op_a : op_a;
                    m_abs_b = (div_signed && op_b[31]) ? 32'd0 - op_b : op_b;
                end
            end
            exp_done  = (m_done_at == m_n);
            exp_start = m_pend && (m_n == m_e0);
            exp_stall = m_pend ? 1'b1 : (exp_done ? 1'b0 : (div_req && !flush));
            check("done",     32'(done),     32'(exp_done));
            check("stall",    32'(stall),    32'(exp_stall));
            check("dv_start", 32'(dv_start), 32'(exp_start));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (exp_start) begin
                check("dv_a", dv_a, m_abs_a);
                check("dv_b", dv_b, m_abs_b);
            end
            m_busy_prev = dv_busy;
        end
    end

    task automatic drive_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int lat);
        @(negedge clock);
        #1;
        div_signed = sgn;
        op_a       = a;
        op_b       = b;
        lat_cfg    = lat;
        div_req    = 1'b1;
    endtask

    task automatic wait_done(output int cnt);
        bit got = 0;
        cnt = 0;
        while (!got && cnt < 200) begin
            @(negedge clock);
            cnt++;
            if (done) got = 1;
        end
        #1;
        div_req = 1'b0;
        check("done_seen", 32'(got), 32'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cnt;
        int s0;
        div_req = 1'b1;
        op_a    = 32'h55;
        op_b    = 32'h3;
        repeat (2) @(negedge clock);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_start", 32'(dv_start), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dv_a", dv_a, 32'd0);
        check("rst_dv_b", dv_b, 32'd0);
        div_req = 1'b0;
        resetn  = 1'b1;

        s0 = start_cnt;
        drive_op(0, 32'd1000000000, 32'd999999999, 5);
        wait_done(cnt);
        check("u_big_lat", cnt, 32'd9);
        check("u_big_lo", lo, 32'd1);
        check("u_big_hi", hi, 32'd1);
        check("u_big_starts", 32'(start_cnt - s0), 32'd1);

        drive_op(1, 32'hFFFF_FFF9, 32'd2, 4);
        wait_done(cnt);
        check("s_m7_lat", cnt, 32'd8);
        check("s_m7_lo", lo, 32'hFFFF_FFFD);
        check("s_m7_hi", hi, 32'hFFFF_FFFF);

        drive_op(0, 32'hFFFF_FFF9, 32'd2, 6);
        wait_done(cnt);
        check("u_m7_lo", lo, 32'h7FFF_FFFC);
        check("u_m7_hi", hi, 32'd1);

        s0 = start_cnt;
        drive_op(0, 32'h1234, 32'd0, 3);
        wait_done(cnt);
        check("div0_lat", cnt, 32'd1);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'h1234);
        check("div0_starts", 32'(start_cnt - s0), 32'd0);

        drive_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 2);
        wait_done(cnt);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // flush while the result is being committed
        drive_op(0, 32'd77, 32'd6, 2);
        wait_done(cnt);
        flush = 1'b1;
        @(negedge clock);
        #1;
        flush = 1'b0;
        check("flush_done_lo", lo, 32'd12);
        check("flush_done_hi", hi, 32'd5);

        // flush in WAIT_DONE, then a request held through DRAIN
        drive_op(0, 32'd50, 32'd3, 8);
        repeat (4) @(negedge clock);
        #1;
        flush   = 1'b1;
        div_req = 1'b0;
        @(negedge clock);
        #1;
        flush = 1'b0;
        check("flush_wd_lo", lo, 32'd12);
        check("flush_wd_hi", hi, 32'd5);
        drive_op(0, 32'd100, 32'd7, 3);
        wait_done(cnt);
        check("drain_lat", cnt, 32'd12);
        check("after_drain_lo", lo, 32'd14);
        check("after_drain_hi", hi, 32'd2);

        // request masked by flush while idle
        drive_op(0, 32'd9, 32'd4, 2);
        flush = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        flush = 1'b0;
        wait_done(cnt);
        check("idle_flush_lo", lo, 32'd2);
        check("idle_flush_hi", hi, 32'd1);

        // asynchronous reset in WAIT_DONE with the request still held
        drive_op(0, 32'd1000, 32'd3, 10);
        repeat (5) @(negedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_done",  32'(done),  32'd0);
        check("arst_start", 32'(dv_start), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_dv_a", dv_a, 32'd0);
        check("arst_dv_b", dv_b, 32'd0);
        #1;
        resetn = 1'b1;
        wait_done(cnt);
        check("arst_lat", cnt, 32'd14);
        check("arst_lo_after", lo, 32'd333);
        check("arst_hi_after", hi, 32'd1);

        for (int i = 0; i < 150; i++) begin
            bit          sgn;
            logic [31:0] a, b;
            int          lat, fk;
            bit          got;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            lat = $urandom_range(1, 6);
            fk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 5) : -1;
            drive_op(sgn, a, b, lat);
            if (fk < 0) begin
                wait_done(cnt);
            end else begin
                got = 0;
                for (int k = 1; k <= fk; k++) begin
                    @(negedge clock);
                    if (done) begin
                        got = 1;
                        break;
                    end
                end
                #1;
                div_req = 1'b0;
                if (!got) begin
                    flush = 1'b1;
                    @(negedge clock);
                    #1;
                    flush = 1'b0;
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (12) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have a single clock, clock (input, 1), and all state SHALL be clocked on its rising edge.
REQ-002 SHALL have reset resetn (input, 1), asynchronous and active-low.
REQ-003 div_req (input, 1): divide request from the execute stage, held until done.
REQ-004 div_signed (input, 1): 1 = DIV (signed), 0 = DIVU (unsigned); sampled with div_req.
REQ-005 op_a, op_b (input, 32 each): dividend and divisor; sampled on acceptance.
REQ-006 flush (input, 1): pipeline flush; aborts any in-flight operation.
REQ-007 dv_start (output, 1), dv_a and dv_b (output, 32 each): drive the unsigned divider.
REQ-008 dv_busy (input, 1), dv_q and dv_r (input, 32 each): divider status and results.
REQ-009 stall (output, 1): freezes the upstream pipeline while a divide is pending.
REQ-010 done (output, 1): one-cycle pulse when HI/LO are updated.
REQ-011 hi and lo (output, 32 each): architectural HI (remainder) and LO (quotient) registers.

Function
REQ-012 SHALL use the states IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, FIX, DONE and DRAIN.
REQ-013 In IDLE, div_req && !flush SHALL latch op_a, op_b and div_signed, then go to LAUNCH; if op_b == 0 it SHALL go to DONE instead.
REQ-014 LAUNCH SHALL assert dv_start for exactly one cycle, with dv_a = |op_a| and dv_b = |op_b| when signed (raw values when unsigned), then go to WAIT_ACK.
REQ-015 WAIT_ACK SHALL go to WAIT_DONE on dv_busy == 1.
REQ-016 WAIT_DONE SHALL capture dv_q and dv_r and go to FIX on dv_busy == 0.
REQ-017 FIX (signed only) SHALL negate the quotient if the operand signs differ, and negate the remainder if op_a is negative; unsigned SHALL pass through unchanged. FIX SHALL then go to DONE.
REQ-018 DONE SHALL write lo/hi, pulse done for one cycle, deassert stall, then return to IDLE.
REQ-019 Divide by zero SHALL set lo = 32'hFFFF_FFFF and hi = op_a, with no dv_start.
REQ-020 Signed 0x8000_0000 / 0xFFFF_FFFF SHALL give lo = 0x8000_0000 and hi = 0, with no trap.
REQ-021 stall SHALL equal (state ∉ {IDLE, DONE, DRAIN}) || (state ∈ {IDLE, DRAIN} && div_req && !flush).
REQ-022 A flush in LAUNCH, WAIT_ACK, WAIT_DONE or FIX SHALL discard the operation, leave hi/lo unchanged, and go to DRAIN if dv_busy or the divider has been started, otherwise to IDLE.
REQ-023 DRAIN SHALL wait for dv_busy == 0 (ignoring dv_q/dv_r), then go to IDLE; div_req SHALL NOT be accepted in DRAIN.
REQ-024 A flush in DONE SHALL NOT cancel the hi/lo write, since the result is committed.
REQ-025 Latency for a nonzero divisor SHALL be the divider latency + 4 cycles, from acceptance to the done pulse.

Reset
REQ-026 resetn low SHALL immediately force state = IDLE, hi = lo = 0, dv_start = 0, stall = 0, done = 0 and dv_a = dv_b = 0, from any state.
REQ-027 After release, the first request SHALL be accepted on the first rising edge with div_req high.

Structure
REQ-028 The state encoding, the 32-bit data width and the divide-by-zero LO constant SHALL live in shared package div_pkg.
REQ-029 Absolute value and conditional negation SHALL be one combinational sub-module, div_sign_fix, instantiated for both operand preparation and result fixup.
REQ-030 The divider itself SHALL NOT be instantiated here; the two blocks SHALL be connected at the CPU top level.

Verification
REQ-031 Unsigned 1000000000 / 999999999 -> lo = 1, hi = 1, one done pulse, stall low only after done.
REQ-032 Signed -7 / 2 (0xFFFF_FFF9 / 2) -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF; unsigned run of the same operands -> lo = 0x7FFF_FFFC, hi = 1.
REQ-033 op_a = 0x1234, op_b = 0 -> done within 2 cycles, lo = 0xFFFF_FFFF, hi = 0x1234, dv_start never asserted.
REQ-034 Signed 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0.
REQ-035 Flush during WAIT_DONE -> hi/lo keep their prior values, no done pulse, DRAIN until dv_busy falls; a new 100 / 7 then yields lo = 14, hi = 2.
REQ-036 resetn pulsed low mid-WAIT_DONE -> all outputs 0 within the same cycle, state IDLE; the next request completes normally.
